axis_video_tx: RTL and testbench

AXI4-Stream video transmit stage at the output end of the sharpening pipeline. It accepts result pixels from the kernel datapath on a valid/ready pixel port and buffers them in a 2-entry skid FIFO. It drives a fully compliant AXI4-Stream video master toward the VDMA. The master `tuser` (SOF) and `tlast` (EOL) are regenerated from its own raster counters, upstream markers are checked against them, and it reports frame completion and marker errors.

---
 rtl/axis_video_tx_if.sv | 13 +
 rtl/axis_video_tx.sv | 137 +++++++++++++
 tb/tb_axis_video_tx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_video_tx_if.sv
// AXI4-Stream style handshake bundle shared by the pixel input and video output ports.
interface axis_video_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tuser;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_tx.sv
// Video transmit stage: 2-entry skid FIFO feeding an AXI4-Stream video master.
// SOF/EOL on the output are regenerated from the local raster counters; the
// upstream markers are only checked against them (with SOF resync).
module axis_video_tx #(
    parameter int PXL_D_WIDTH  = 8,
    parameter int IN_HORZ_SIZE = 1280,
    parameter int IN_VERT_SIZE = 720
) (
    input  logic            clk,
    input  logic            rst_n,
    axis_video_tx_if.slave  s_pix,
    axis_video_tx_if.master m_axis,
    output logic            frame_done,
    output logic            err_sof,
    output logic            err_eol,
    input  logic            err_clr
);
    localparam int XW = (IN_HORZ_SIZE > 1) ? $clog2(IN_HORZ_SIZE) : 1;
    localparam int YW = (IN_VERT_SIZE > 1) ? $clog2(IN_VERT_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IN_HORZ_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_VERT_SIZE - 1);
    localparam int EW = PXL_D_WIDTH + 2;

    // Entry layout: {tuser, tlast, tdata}
    logic [EW-1:0]          mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q, count_d;
    logic                   rdy_q;
    logic [XW-1:0]          x_cnt_q, x_cnt_d, base_x;
    logic [YW-1:0]          y_cnt_q, y_cnt_d, base_y;
    logic                   frame_done_q;
    logic                   err_sof_q, err_sof_d;
    logic                   err_eol_q, err_eol_d;

    logic [EW-1:0]          head;
    logic [PXL_D_WIDTH-1:0] head_data;
    logic                   head_user, head_last;
    logic                   s_ready, m_valid, push, pop;
    logic                   at_origin, at_eol, at_end, resync;
    logic                   sof_err_set, eol_err_set;

    assign head      = mem_q[rd_ptr_q];
    assign head_data = head[PXL_D_WIDTH-1:0];
    assign head_last = head[PXL_D_WIDTH];
    assign head_user = head[PXL_D_WIDTH+1];

    // Ready depends only on local state, never on the downstream tready.
    assign s_ready = rdy_q & (count_q != 2'd2);
    assign m_valid = (count_q != 2'd0);
    assign push    = s_pix.tvalid & s_ready;
    assign pop     = m_valid & m_axis.tready;

    assign at_origin = (x_cnt_q == '0) && (y_cnt_q == '0);
    assign at_eol    = (x_cnt_q == X_LAST);
    assign at_end    = at_eol && (y_cnt_q == Y_LAST);
    // An upstream SOF away from (0,0) restarts the raster on this beat.
    assign resync    = head_user & ~at_origin;

    assign sof_err_set = pop & (resync | (at_origin & ~head_user));
    assign eol_err_set = pop & (head_last != at_eol);

    assign s_pix.tready  = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = head_data;
    // Markers are gated by valid so an empty FIFO presents clean zeros.
    assign m_axis.tuser  = m_valid & (head_user | at_origin);
    assign m_axis.tlast  = m_valid & at_eol;

    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;
    assign err_eol    = err_eol_q;

    // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Raster advance on pop; a resync beat counts as pixel 0 of a new frame.
    always_comb begin
        base_x  = resync ? '0 : x_cnt_q;
        base_y  = resync ? '0 : y_cnt_q;
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (pop) begin
            if (base_x == X_LAST) begin
                x_cnt_d = '0;
                y_cnt_d = (base_y == Y_LAST) ? '0 : base_y + YW'(1);
            end else begin
                x_cnt_d = base_x + XW'(1);
                y_cnt_d = base_y;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats the clear.
    always_comb begin
        err_sof_d = sof_err_set | (err_sof_q & ~err_clr);
        err_eol_d = eol_err_set | (err_eol_q & ~err_clr);
    end

    // FIFO storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_pix.tuser, s_pix.tlast, s_pix.tdata};
        end
    end

    // Control state, raster counters and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            rdy_q        <= 1'b0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
            err_eol_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q      <= count_d;
            rdy_q        <= 1'b1;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            frame_done_q <= pop & at_end;
            err_sof_q    <= err_sof_d;
            err_eol_q    <= err_eol_d;
        end
    end
endmodule

// File: tb/tb_axis_video_tx.sv
// Directed bench for axis_video_tx with a 4x3 raster.
module tb_axis_video_tx;
    localparam int W = 8;
    localparam int H = 4;
    localparam int V = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic frame_done, err_sof, err_eol;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] out_d [$];
    logic       out_u [$];
    logic       out_l [$];
    int         fd_pos [$];

    always #5 clk = ~clk;

    axis_video_tx_if #(.DATA_W(W)) s_if ();
    axis_video_tx_if #(.DATA_W(W)) m_if ();

    axis_video_tx #(
        .PXL_D_WIDTH (W),
        .IN_HORZ_SIZE(H),
        .IN_VERT_SIZE(V)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_pix     (s_if),
        .m_axis    (m_if),
        .frame_done(frame_done),
        .err_sof   (err_sof),
        .err_eol   (err_eol),
        .err_clr   (err_clr)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every handed-off beat and the beat count at each frame_done pulse.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_pos.push_back(out_d.size());
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            $display("beat %0d: data=0x%02h tuser=%0b tlast=%0b", out_d.size(), m_if.tdata, m_if.tuser, m_if.tlast);
            out_d.push_back(m_if.tdata);
            out_u.push_back(m_if.tuser);
            out_l.push_back(m_if.tlast);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        out_d.delete();
        out_u.delete();
        out_l.delete();
        fd_pos.delete();
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        err_clr     = 1'b0;
        rst_n       = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Present one pixel (called at posedge+1) and hold it until accepted.
    task automatic push_pixel(input logic [7:0] d, input logic u, input logic l);
        bit done = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        for (int w = 0; w < 50 && !done; w++) begin
            @(negedge clk);
            done = s_if.tready;
            next_cycle();
        end
        if (!done) check_value("push_timeout", 32'd0, 32'd1);
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        bit         acc, pop, stall_prev;
        logic [7:0] held;
        int         sent, model_cnt;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_s_tready", s_if.tready, 0);
        check_value("rst_m_tvalid", m_if.tvalid, 0);
        check_value("rst_m_tuser", m_if.tuser, 0);
        check_value("rst_m_tlast", m_if.tlast, 0);
        check_value("rst_frame_done", frame_done, 0);
        check_value("rst_err_sof", err_sof, 0);
        check_value("rst_err_eol", err_eol, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ---- Streaming: 12 pixels, output is input delayed one cycle ----
        clear_log();
        m_if.tready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            s_if.tvalid = (k < 12);
            s_if.tdata  = 8'(k);
            s_if.tuser  = (k == 0);
            s_if.tlast  = (k % 4 == 3);
            @(negedge clk);
            if (k == 0) begin
                check_value("str_idle_valid", m_if.tvalid, 0);
            end else begin
                check_value($sformatf("str_valid_%0d", k - 1), m_if.tvalid, 1);
                check_value($sformatf("str_data_%0d", k - 1), m_if.tdata, k - 1);
                check_value($sformatf("str_tuser_%0d", k - 1), m_if.tuser, (k - 1) == 0);
                check_value($sformatf("str_tlast_%0d", k - 1), m_if.tlast, (k - 1) % 4 == 3);
            end
            if (k < 12) check_value($sformatf("str_s_tready_%0d", k), s_if.tready, 1);
            next_cycle();
        end
        @(negedge clk);
        check_value("str_frame_done", frame_done, 1);
        check_value("str_drained", m_if.tvalid, 0);
        next_cycle();
        @(negedge clk);
        check_value("str_frame_done_once", frame_done, 0);
        check_value("str_err_sof", err_sof, 0);
        check_value("str_err_eol", err_eol, 0);
        next_cycle();

        // ---- Randomized backpressure over 3 frames ----
        clear_log();
        sent = 0;
        model_cnt = 0;
        stall_prev = 1'b0;
        held = '0;
        s_if.tvalid = 1'b0;
        for (int cyc = 0; cyc < 3000 && out_d.size() < 36; cyc++) begin
            if (!s_if.tvalid && sent < 36 && $urandom_range(1) == 1) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = 8'(sent);
                s_if.tuser  = (sent % 12 == 0);
                s_if.tlast  = (sent % 4 == 3);
            end
            m_if.tready = ($urandom_range(1) == 1);
            @(negedge clk);
            check_value("rnd_s_tready", s_if.tready, model_cnt != 2);
            if (stall_prev) begin
                check_value("rnd_stall_valid", m_if.tvalid, 1);
                check_value("rnd_stall_data", m_if.tdata, held);
            end
            acc = s_if.tvalid && s_if.tready;
            pop = m_if.tvalid && m_if.tready;
            stall_prev = m_if.tvalid && !m_if.tready;
            held = m_if.tdata;
            next_cycle();
            model_cnt = model_cnt + int'(acc) - int'(pop);
            if (acc) begin
                sent++;
                s_if.tvalid = 1'b0;
            end
        end
        m_if.tready = 1'b0;
        repeat (2) next_cycle();
        check_value("rnd_beat_count", out_d.size(), 36);
        for (int i = 0; i < out_d.size(); i++) begin
            check_value($sformatf("rnd_data_%0d", i), out_d[i], i);
            check_value($sformatf("rnd_tuser_%0d", i), out_u[i], i % 12 == 0);
            check_value($sformatf("rnd_tlast_%0d", i), out_l[i], i % 4 == 3);
        end
        check_value("rnd_frame_done_count", fd_pos.size(), 3);
        for (int j = 0; j < fd_pos.size(); j++)
            check_value($sformatf("rnd_frame_done_pos_%0d", j), fd_pos[j], 12 * (j + 1));
        check_value("rnd_err_sof", err_sof, 0);
        check_value("rnd_err_eol", err_eol, 0);

        // ---- Missing EOL on pixel 0x03 ----
        do_reset();
        clear_log();
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) push_pixel(8'(i), i == 0, 1'b0);
        @(negedge clk);
        check_value("eol_before_pop", err_eol, 0);
        next_cycle();
        @(negedge clk);
        check_value("eol_err_set", err_eol, 1);
        check_value("eol_out_data3", out_d.size() > 3 ? out_d[3] : 8'hFF, 3);
        check_value("eol_out_tlast3", out_d.size() > 3 ? out_l[3] : 1'b0, 1);
        check_value("eol_err_sof", err_sof, 0);
        next_cycle();
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        @(negedge clk);
        check_value("eol_err_cleared", err_eol, 0);
        next_cycle();

        // ---- Early SOF at pixel index 6 ----
        do_reset();
        clear_log();
        m_if.tready = 1'b1;
        for (int i = 0; i < 6; i++) push_pixel(8'(i), i == 0, i % 4 == 3);
        push_pixel(8'd6, 1'b1, 1'b0);
        @(negedge clk);
        check_value("sof_head_data", m_if.tdata, 6);
        check_value("sof_head_tuser", m_if.tuser, 1);
        check_value("sof_err_before_pop", err_sof, 0);
        next_cycle();
        @(negedge clk);
        check_value("sof_err_set", err_sof, 1);
        next_cycle();
        for (int i = 7; i < 18; i++) push_pixel(8'(i), 1'b0, (i - 6) % 4 == 3);
        repeat (3) next_cycle();
        check_value("sof_beat_count", out_d.size(), 18);
        if (out_d.size() >= 18) begin
            check_value("sof_out_tuser6", out_u[6], 1);
            check_value("sof_out_tlast7", out_l[7], 0);
            check_value("sof_out_tlast8", out_l[8], 0);
            check_value("sof_out_tlast9", out_l[9], 1);
            check_value("sof_out_tlast17", out_l[17], 1);
        end
        check_value("sof_frame_done_count", fd_pos.size(), 1);
        if (fd_pos.size() > 0) check_value("sof_frame_done_pos", fd_pos[0], 18);
        check_value("sof_err_eol", err_eol, 0);

        // ---- Reset mid-frame with two pixels held ----
        do_reset();
        clear_log();
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) push_pixel(8'(i), i == 0, i % 4 == 3);
        m_if.tready = 1'b0;
        push_pixel(8'd4, 1'b0, 1'b0);
        @(negedge clk);
        check_value("mid_full_s_tready", s_if.tready, 0);
        check_value("mid_full_valid", m_if.tvalid, 1);
        check_value("mid_full_head", m_if.tdata, 3);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        check_value("mid_rst_valid", m_if.tvalid, 0);
        check_value("mid_rst_s_tready", s_if.tready, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        m_if.tready = 1'b1;
        push_pixel(8'h20, 1'b0, 1'b0);
        @(negedge clk);
        check_value("mid_first_valid", m_if.tvalid, 1);
        check_value("mid_first_data", m_if.tdata, 8'h20);
        check_value("mid_first_tuser", m_if.tuser, 1);
        check_value("mid_first_tlast", m_if.tlast, 0);
        check_value("mid_held_discarded", out_d.size(), 3);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
